vend_sequencer: RTL and testbench

- Central controller for the vending machine: accumulates coin credit, arbitrates soda/diet selection, sequences the dispense mechanism over a req/ack handshake, then pays out change one nickel at a time.
- Sits between the coin acceptor and selection buttons on one side, and the dispense motors and nickel hopper on the other.
- Credit is tracked in nickel units. The machine has a single active transaction at a time.

---
 rtl/vend_sequencer_if.sv | 48 ++++
 rtl/vend_sequencer.sv | 171 +++++++++++++++++
 tb/tb_vend_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_sequencer_if.sv
// ---------------------------------------------------------------------------
// vend_sequencer_if
//   Bundle of the signals between the vending sequencer and its surroundings.
//   The coin acceptor, selection buttons, stock sensors, dispense mechanism
//   and nickel hopper connect through the master side. The sequencer
//   connects through the slave side.
//
//   Coin acceptor : N, D, Q            1-cycle pulses, one per accepted coin
//   Buttons       : soda, diet, cancel level inputs
//   Stock sensors : soda_empty, diet_empty
//   Dispense      : GiveSoda / GiveDiet request, disp_ack completion
//   Hopper        : chg_nickel request, chg_ack one-nickel-released
//   Status        : coin_reject pulse, credit (in nickels), busy
// ---------------------------------------------------------------------------
interface vend_sequencer_if #(
   parameter int CW = 5
);
   logic          N;
   logic          D;
   logic          Q;
   logic          soda;
   logic          diet;
   logic          cancel;
   logic          soda_empty;
   logic          diet_empty;
   logic          disp_ack;
   logic          chg_ack;
   logic          GiveSoda;
   logic          GiveDiet;
   logic          chg_nickel;
   logic          coin_reject;
   logic [CW-1:0] credit;
   logic          busy;

   // Environment side: drives the machine inputs, observes the controller.
   modport master (
      output N, D, Q, soda, diet, cancel, soda_empty, diet_empty,
             disp_ack, chg_ack,
      input  GiveSoda, GiveDiet, chg_nickel, coin_reject, credit, busy
   );

   // Controller side.
   modport slave (
      input  N, D, Q, soda, diet, cancel, soda_empty, diet_empty,
             disp_ack, chg_ack,
      output GiveSoda, GiveDiet, chg_nickel, coin_reject, credit, busy
   );
endinterface

// File: rtl/vend_sequencer.sv
// ---------------------------------------------------------------------------
// vend_sequencer
//   Central vending controller. Accumulates coin credit in nickel units,
//   arbitrates soda/diet selections, runs the dispense req/ack handshake and
//   then pays out change one nickel at a time over the hopper handshake.
//
//   Ports:
//     CLK    system clock, rising edge
//     reset  synchronous, active-low reset
//     bus    vend_sequencer_if.slave
//              in : N, D, Q, soda, diet, cancel, soda_empty, diet_empty,
//                   disp_ack, chg_ack
//              out: GiveSoda, GiveDiet, chg_nickel, coin_reject, credit, busy
//
//   Parameters:
//     PRICE       product price in nickels
//     MAX_CREDIT  credit ceiling in nickels; coins that would pass it bounce
//     CW          credit register width, must hold MAX_CREDIT+5
//
//   Every output is a register; a response appears the cycle after the edge
//   that sampled its cause.
// ---------------------------------------------------------------------------
module vend_sequencer #(
   parameter int PRICE      = 9,
   parameter int MAX_CREDIT = 15,
   parameter int CW         = 5
) (
   input  logic           CLK,
   input  logic           reset,
   vend_sequencer_if.slave bus
);

   localparam logic [CW-1:0] PRICE_C   = CW'(PRICE);
   localparam logic [CW:0]   MAX_C     = (CW+1)'(MAX_CREDIT);
   localparam logic [CW-1:0] NICKEL_V  = CW'(1);
   localparam logic [CW-1:0] DIME_V    = CW'(2);
   localparam logic [CW-1:0] QUARTER_V = CW'(5);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CREDIT = 2'd1,
      VEND   = 2'd2,
      CHANGE = 2'd3
   } state_t;

   state_t        state_reg;
   logic [CW-1:0] credit_reg;
   logic          give_soda_reg;
   logic          give_diet_reg;
   logic          chg_nickel_reg;
   logic          coin_reject_reg;
   logic          busy_reg;

   // Coin decode and selection qualification, all against registered credit.
   logic [CW-1:0] coin_value;
   logic [CW:0]   coin_sum;
   logic          any_coin;
   logic          multi_coin;
   logic          coin_fits;
   logic          coin_lost;
   logic          sel_soda;
   logic          sel_diet;

   always_comb begin
      coin_value = '0;
      if (bus.Q) begin
         coin_value = QUARTER_V;
      end else if (bus.D) begin
         coin_value = DIME_V;
      end else if (bus.N) begin
         coin_value = NICKEL_V;
      end

      any_coin   = bus.N | bus.D | bus.Q;
      // Only the highest-value coin can ever be credited; any second coin in
      // the same cycle is bounced.
      multi_coin = (bus.N & bus.D) | (bus.N & bus.Q) | (bus.D & bus.Q);

      // One extra bit so the ceiling test cannot be fooled by wrap-around.
      coin_sum   = {1'b0, credit_reg} + {1'b0, coin_value};
      coin_fits  = any_coin && (coin_sum <= MAX_C);
      coin_lost  = multi_coin || (any_coin && !coin_fits);

      sel_soda   = bus.soda && (credit_reg >= PRICE_C) && !bus.soda_empty;
      sel_diet   = bus.diet && (credit_reg >= PRICE_C) && !bus.diet_empty;
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         state_reg       <= IDLE;
         credit_reg      <= '0;
         give_soda_reg   <= 1'b0;
         give_diet_reg   <= 1'b0;
         chg_nickel_reg  <= 1'b0;
         coin_reject_reg <= 1'b0;
         busy_reg        <= 1'b0;
      end else begin
         coin_reject_reg <= 1'b0;

         case (state_reg)
            IDLE, CREDIT: begin
               // IDLE holds zero credit, so cancel and selections can only
               // matter once some credit exists.
               if ((state_reg == CREDIT) && bus.cancel) begin
                  state_reg       <= CHANGE;
                  chg_nickel_reg  <= 1'b1;
                  busy_reg        <= 1'b1;
                  coin_reject_reg <= any_coin;
               end else if ((state_reg == CREDIT) && sel_soda) begin
                  state_reg       <= VEND;
                  give_soda_reg   <= 1'b1;
                  busy_reg        <= 1'b1;
                  coin_reject_reg <= any_coin;
               end else if ((state_reg == CREDIT) && sel_diet) begin
                  state_reg       <= VEND;
                  give_diet_reg   <= 1'b1;
                  busy_reg        <= 1'b1;
                  coin_reject_reg <= any_coin;
               end else begin
                  if (coin_fits) begin
                     credit_reg <= coin_sum[CW-1:0];
                     state_reg  <= CREDIT;
                  end
                  coin_reject_reg <= coin_lost;
               end
            end

            VEND: begin
               coin_reject_reg <= any_coin;
               if (bus.disp_ack) begin
                  // credit >= PRICE is guaranteed on entry to VEND.
                  credit_reg    <= credit_reg - PRICE_C;
                  give_soda_reg <= 1'b0;
                  give_diet_reg <= 1'b0;
                  if (credit_reg > PRICE_C) begin
                     state_reg      <= CHANGE;
                     chg_nickel_reg <= 1'b1;
                  end else begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end
               end
            end

            CHANGE: begin
               coin_reject_reg <= any_coin;
               if (bus.chg_ack && chg_nickel_reg) begin
                  credit_reg <= credit_reg - NICKEL_V;
                  if (credit_reg == NICKEL_V) begin
                     chg_nickel_reg <= 1'b0;
                     state_reg      <= IDLE;
                     busy_reg       <= 1'b0;
                  end
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.GiveSoda    = give_soda_reg;
   assign bus.GiveDiet    = give_diet_reg;
   assign bus.chg_nickel  = chg_nickel_reg;
   assign bus.coin_reject = coin_reject_reg;
   assign bus.credit      = credit_reg;
   assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_vend_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vend_sequencer
//   Directed bench for vend_sequencer. A transaction-level model tracks the
//   machine as "what is happening now" (nothing / vending soda / vending
//   diet / paying change) plus a credit count, and every cycle after reset
//   the DUT outputs are compared against what that model implies. Literal
//   hand-computed expectations along the directed scenarios pin the model.
// ---------------------------------------------------------------------------
module tb_vend_sequencer;

   localparam int PRICE      = 9;
   localparam int MAX_CREDIT = 15;
   localparam int CW         = 5;

   // Model activity codes.
   localparam int A_NONE  = 0;
   localparam int A_SODA  = 1;
   localparam int A_DIET  = 2;
   localparam int A_PAY   = 3;

   logic CLK;
   logic reset;

   vend_sequencer_if #(.CW(CW)) bus ();

   vend_sequencer #(
      .PRICE     (PRICE),
      .MAX_CREDIT(MAX_CREDIT),
      .CW        (CW)
   ) dut (
      .CLK  (CLK),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   int m_act    = A_NONE;
   int m_credit = 0;
   bit m_rej    = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Next model state from the current inputs and the model's own history.
   function automatic void model_step(output int na, output int nc, output bit nr);
      int value;
      int ncoins;
      bit took;
      na     = m_act;
      nc     = m_credit;
      nr     = 1'b0;
      value  = bus.Q ? 5 : (bus.D ? 2 : (bus.N ? 1 : 0));
      ncoins = int'(bus.N) + int'(bus.D) + int'(bus.Q);
      took   = 1'b0;
      if (!reset) begin
         na = A_NONE;
         nc = 0;
         nr = 1'b0;
      end else if (m_act == A_NONE) begin
         if (m_credit > 0 && bus.cancel) begin
            na = A_PAY;
         end else if (m_credit >= PRICE && bus.soda && !bus.soda_empty) begin
            na = A_SODA;
         end else if (m_credit >= PRICE && bus.diet && !bus.diet_empty) begin
            na = A_DIET;
         end else if (value > 0 && m_credit + value <= MAX_CREDIT) begin
            nc   = m_credit + value;
            took = 1'b1;
         end
         nr = (ncoins > int'(took));
      end else if (m_act == A_SODA || m_act == A_DIET) begin
         nr = (ncoins > 0);
         if (bus.disp_ack) begin
            nc = m_credit - PRICE;
            na = (nc > 0) ? A_PAY : A_NONE;
         end
      end else begin
         nr = (ncoins > 0);
         if (bus.chg_ack) begin
            nc = m_credit - 1;
            if (nc == 0) na = A_NONE;
         end
      end
   endfunction

   always @(posedge CLK) begin : model
      int na;
      int nc;
      bit nr;
      model_step(na, nc, nr);
      m_act    <= na;
      m_credit <= nc;
      m_rej    <= nr;
   end

   always @(negedge CLK) begin
      if (check_en) begin
         chk("cyc_GiveSoda",    int'(bus.GiveSoda),    int'(m_act == A_SODA));
         chk("cyc_GiveDiet",    int'(bus.GiveDiet),    int'(m_act == A_DIET));
         chk("cyc_chg_nickel",  int'(bus.chg_nickel),  int'(m_act == A_PAY));
         chk("cyc_busy",        int'(bus.busy),        int'(m_act != A_NONE));
         chk("cyc_coin_reject", int'(bus.coin_reject), int'(m_rej));
         chk("cyc_credit",      int'(bus.credit),      m_credit);
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic coin(input bit n, input bit d, input bit q);
      bus.N = n;
      bus.D = d;
      bus.Q = q;
      cyc(1);
      bus.N = 1'b0;
      bus.D = 1'b0;
      bus.Q = 1'b0;
      $display("coin N=%0b D=%0b Q=%0b -> credit=%0d reject=%0b",
               n, d, q, bus.credit, bus.coin_reject);
   endtask

   task automatic disp_pulse();
      bus.disp_ack = 1'b1;
      cyc(1);
      bus.disp_ack = 1'b0;
      $display("disp_ack -> credit=%0d busy=%0b chg_nickel=%0b",
               bus.credit, bus.busy, bus.chg_nickel);
   endtask

   initial begin
      reset          = 1'b0;
      bus.N          = 1'b0;
      bus.D          = 1'b0;
      bus.Q          = 1'b0;
      bus.soda       = 1'b0;
      bus.diet       = 1'b0;
      bus.cancel     = 1'b0;
      bus.soda_empty = 1'b0;
      bus.diet_empty = 1'b0;
      bus.disp_ack   = 1'b0;
      bus.chg_ack    = 1'b0;
      cyc(2);
      check_en = 1'b1;
      chk("rst_credit", int'(bus.credit), 0);
      chk("rst_busy",   int'(bus.busy), 0);
      chk("rst_give",   int'(bus.GiveSoda | bus.GiveDiet | bus.chg_nickel), 0);
      reset = 1'b1;
      cyc(1);

      // Q,D,D then soda, dispense after 3 cycles.
      coin(0, 0, 1); chk("t1_q", int'(bus.credit), 5);
      cyc(1);
      coin(0, 1, 0); chk("t1_d1", int'(bus.credit), 7);
      cyc(1);
      coin(0, 1, 0); chk("t1_d2", int'(bus.credit), 9);
      bus.soda = 1'b1; cyc(1); bus.soda = 1'b0;
      chk("t1_give_soda", int'(bus.GiveSoda), 1);
      chk("t1_busy", int'(bus.busy), 1);
      cyc(3);
      chk("t1_give_held", int'(bus.GiveSoda), 1);
      disp_pulse();
      chk("t1_give_drop", int'(bus.GiveSoda), 0);
      chk("t1_credit0", int'(bus.credit), 0);
      chk("t1_idle", int'(bus.busy), 0);

      // Ceiling at 15, diet vend, six nickels of change.
      coin(0, 0, 1); coin(0, 1, 0); coin(0, 1, 0);
      coin(0, 0, 1); chk("t2_q14", int'(bus.credit), 14);
      coin(1, 0, 0); chk("t2_n15", int'(bus.credit), 15);
      coin(1, 0, 0);
      chk("t2_reject", int'(bus.coin_reject), 1);
      chk("t2_hold15", int'(bus.credit), 15);
      bus.diet = 1'b1; cyc(1); bus.diet = 1'b0;
      chk("t2_give_diet", int'(bus.GiveDiet), 1);
      cyc(2);
      disp_pulse();
      chk("t2_credit6", int'(bus.credit), 6);
      chk("t2_chg", int'(bus.chg_nickel), 1);
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         bus.chg_ack = 1'b1; cyc(1); bus.chg_ack = 1'b0;
         chk("t2_payout", int'(bus.credit), 5 - i);
      end
      chk("t2_chg_done", int'(bus.chg_nickel), 0);
      chk("t2_idle", int'(bus.busy), 0);
      $display("t2 done: credit=%0d", bus.credit);

      // Insufficient credit, then topped up while soda is held.
      coin(0, 0, 1); coin(0, 1, 0);
      bus.soda = 1'b1; cyc(1);
      chk("t3_no_vend", int'(bus.GiveSoda), 0);
      chk("t3_credit7", int'(bus.credit), 7);
      coin(0, 1, 0);
      chk("t3_credit9", int'(bus.credit), 9);
      cyc(1); bus.soda = 1'b0;
      chk("t3_vend", int'(bus.GiveSoda), 1);
      disp_pulse();
      chk("t3_credit0", int'(bus.credit), 0);

      // Empty soda column with both buttons; coin during VEND.
      coin(0, 0, 1); coin(0, 0, 1);
      bus.soda_empty = 1'b1; bus.soda = 1'b1; bus.diet = 1'b1;
      cyc(1);
      bus.soda = 1'b0; bus.diet = 1'b0;
      chk("t4_diet", int'(bus.GiveDiet), 1);
      chk("t4_no_soda", int'(bus.GiveSoda), 0);
      coin(1, 0, 0);
      chk("t4_reject", int'(bus.coin_reject), 1);
      chk("t4_credit10", int'(bus.credit), 10);
      bus.soda_empty = 1'b0;
      disp_pulse();
      chk("t4_credit1", int'(bus.credit), 1);
      bus.chg_ack = 1'b1; cyc(1); bus.chg_ack = 1'b0;
      chk("t4_credit0", int'(bus.credit), 0);
      chk("t4_chg_done", int'(bus.chg_nickel), 0);

      // Cancel with a coming coin; chg_ack held continuously.
      coin(0, 1, 0); coin(1, 0, 0);
      bus.cancel = 1'b1; bus.N = 1'b1; cyc(1);
      bus.cancel = 1'b0; bus.N = 1'b0;
      chk("t5_reject", int'(bus.coin_reject), 1);
      chk("t5_chg", int'(bus.chg_nickel), 1);
      chk("t5_credit3", int'(bus.credit), 3);
      bus.chg_ack = 1'b1;
      cyc(1); chk("t5_c2", int'(bus.credit), 2);
      cyc(1); chk("t5_c1", int'(bus.credit), 1);
      chk("t5_chg_still", int'(bus.chg_nickel), 1);
      cyc(1); chk("t5_c0", int'(bus.credit), 0);
      chk("t5_chg_done", int'(bus.chg_nickel), 0);
      cyc(1); bus.chg_ack = 1'b0;
      chk("t5_no_wrap", int'(bus.credit), 0);

      // Several coins at once and the ceiling from a non-empty credit.
      coin(1, 1, 1);
      chk("t6_multi_credit", int'(bus.credit), 5);
      chk("t6_multi_reject", int'(bus.coin_reject), 1);
      coin(1, 1, 0);
      chk("t6_nd_credit", int'(bus.credit), 7);
      coin(0, 0, 1); chk("t6_q12", int'(bus.credit), 12);
      coin(0, 0, 1);
      chk("t6_q_over", int'(bus.coin_reject), 1);
      chk("t6_hold12", int'(bus.credit), 12);
      bus.cancel = 1'b1; cyc(1); bus.cancel = 1'b0;
      bus.chg_ack = 1'b1; cyc(12); bus.chg_ack = 1'b0;
      chk("t6_drained", int'(bus.credit), 0);
      chk("t6_idle", int'(bus.busy), 0);

      // Reset during VEND, then a stray disp_ack.
      coin(0, 0, 1); coin(0, 1, 0); coin(0, 1, 0);
      bus.soda = 1'b1; cyc(1); bus.soda = 1'b0;
      chk("t7_vend", int'(bus.GiveSoda), 1);
      reset = 1'b0; cyc(1); reset = 1'b1;
      chk("t7_give_drop", int'(bus.GiveSoda), 0);
      chk("t7_credit0", int'(bus.credit), 0);
      chk("t7_busy", int'(bus.busy), 0);
      cyc(2);
      disp_pulse();
      chk("t7_stray_credit", int'(bus.credit), 0);
      chk("t7_stray_busy", int'(bus.busy), 0);
      bus.diet = 1'b1; cyc(1); bus.diet = 1'b0;
      chk("t7_idle_sel", int'(bus.GiveDiet), 0);
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
